// File: rtl/misaligned_load_align_pkg.sv
// Shared types and helpers for the load-alignment unit: FSM states, offset width and access size decode.
package misaligned_load_align_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    localparam int unsigned LLEN_DEFAULT = 64;

    function automatic int unsigned offbits(input int unsigned llen);
        return $clog2(llen / 8);
    endfunction

    // Undefined encodings fall back to a raw copy of beat 0.
    function automatic logic load_illegal(input logic [2:0] funct3, input int unsigned llen);
        return (funct3 == 3'b111) || ((funct3 == 3'b011) && (llen == 32));
    endfunction

    function automatic logic is_flq(input logic [2:0] funct3, input logic fp, input int unsigned llen);
        return (funct3 == 3'b100) && fp && (llen == 128);
    endfunction

    function automatic int unsigned load_size(input logic [2:0] funct3, input logic fp,
                                              input int unsigned llen);
        if (load_illegal(funct3, llen))
            return llen / 8;
        if (is_flq(funct3, fp, llen))
            return 16;
        return 32'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/misaligned_load_align_loadextend.sv
// Combinational byte ordering and sign/zero/NaN-box extension of an aligned load lane.
// Byte reversal is built only when LSU_BIGENDIAN_EN is defined.
module loadextend
    import misaligned_load_align_pkg::*;
#(
    parameter int unsigned LLEN    = LLEN_DEFAULT,
    parameter int unsigned OFFBITS = offbits(LLEN)
) (
    input  logic [LLEN-1:0]  lane,
    input  logic [OFFBITS:0] size,
    input  logic [2:0]       funct3,
    input  logic             fp,
`ifdef LSU_BIGENDIAN_EN
    input  logic             big_endian,
`endif
    output logic [LLEN-1:0]  result
);

    localparam int unsigned LB = LLEN / 8;

    logic [7:0] in_b  [LB];
    logic [7:0] ord_b [LB];
    logic       illegal;
    logic       flq;
    logic       sign;
    logic       fill;

    always_comb begin
        illegal = load_illegal(funct3, LLEN);
        flq     = is_flq(funct3, fp, LLEN);
        for (int unsigned i = 0; i < LB; i++)
            in_b[i] = lane[8*i +: 8];
        ord_b = in_b;
`ifdef LSU_BIGENDIAN_EN
        if (big_endian && !illegal) begin
            for (int unsigned i = 0; i < LB; i++)
                if ((OFFBITS+1)'(i) < size)
                    ord_b[i] = in_b[OFFBITS'(size - (OFFBITS+1)'(i) - (OFFBITS+1)'(1))];
        end
`endif
        sign = ord_b[OFFBITS'(size - (OFFBITS+1)'(1))][7];
        // FP halves/words get ones above the data; plain lb never does.
        if (funct3[2] && !flq)
            fill = 1'b0;
        else if (funct3[1:0] == 2'b00)
            fill = sign;
        else
            fill = sign | fp;
        result = '0;
        for (int unsigned i = 0; i < LB; i++)
            result[8*i +: 8] = ((OFFBITS+1)'(i) < size) ? ord_b[i] : {8{fill}};
        if (illegal)
            result = lane;
    end

endmodule

// File: rtl/misaligned_load_align.sv
// Load-data alignment unit: latches a request, gathers one or two beats, and returns the extended result.
// Optional big-endian support via LSU_BIGENDIAN_EN.
module misaligned_load_align
    import misaligned_load_align_pkg::*;
#(
    parameter int unsigned LLEN    = LLEN_DEFAULT,
    parameter int unsigned OFFBITS = offbits(LLEN)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ReqValidM,
    output logic               ReqReadyM,
    input  logic [OFFBITS-1:0] PAdrM,
    input  logic [2:0]         Funct3M,
    input  logic               FpLoadStoreM,
    input  logic               BigEndianM,
    input  logic               BeatValidM,
    input  logic [LLEN-1:0]    BeatDataM,
    input  logic               FlushM,
    output logic               SpillM,
    output logic               RespValidM,
    input  logic               RespReadyM,
    output logic [LLEN-1:0]    ReadDataM
);

    localparam int unsigned      LB         = LLEN / 8;
    localparam logic [OFFBITS:0] BEAT_BYTES = (OFFBITS+1)'(LB);

    state_t             state;
    logic [2:0]         funct3_q;
    logic               fp_q;
    logic [OFFBITS-1:0] off_q;
    logic [OFFBITS:0]   size_q;
    logic               spill_q;
    logic               resp_valid;
    logic [LLEN-1:0]    lo_buf;
    logic [LLEN-1:0]    hi_buf;
    logic [LLEN-1:0]    read_data;

    logic               req_illegal;
    logic [OFFBITS:0]   req_size;
    logic [OFFBITS:0]   req_end;
    logic               req_spill;

    logic [LLEN-1:0]    lo_sel;
    logic [LLEN-1:0]    hi_sel;
    logic [LLEN-1:0]    lane;
    logic [LLEN-1:0]    ext;

`ifdef LSU_BIGENDIAN_EN
    logic               be_q;
`else
    logic               unused_be;
    assign unused_be = BigEndianM;
`endif

    always_comb begin
        req_illegal = load_illegal(Funct3M, LLEN);
        req_size    = (OFFBITS+1)'(load_size(Funct3M, FpLoadStoreM, LLEN));
        req_end     = {1'b0, PAdrM} + req_size;
        req_spill   = !req_illegal && (req_end > BEAT_BYTES);
    end

    // The arriving beat is forwarded so the result can be registered on the same edge it lands.
    assign lo_sel = (state == BEAT0) ? BeatDataM : lo_buf;
    assign hi_sel = (state == BEAT1) ? BeatDataM : hi_buf;
    assign lane   = LLEN'({hi_sel, lo_sel} >> {off_q, 3'b000});

    loadextend #(
        .LLEN    (LLEN),
        .OFFBITS (OFFBITS)
    ) u_loadextend (
        .lane       (lane),
        .size       (size_q),
        .funct3     (funct3_q),
        .fp         (fp_q),
`ifdef LSU_BIGENDIAN_EN
        .big_endian (be_q),
`endif
        .result     (ext)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            funct3_q   <= '0;
            fp_q       <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            spill_q    <= 1'b0;
            lo_buf     <= '0;
            hi_buf     <= '0;
            read_data  <= '0;
            resp_valid <= 1'b0;
`ifdef LSU_BIGENDIAN_EN
            be_q       <= 1'b0;
`endif
        end else if (FlushM) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            spill_q    <= 1'b0;
            lo_buf     <= '0;
            hi_buf     <= '0;
        end else begin
            case (state)
                IDLE: if (ReqValidM) begin
                    funct3_q <= Funct3M;
                    fp_q     <= FpLoadStoreM;
                    off_q    <= req_illegal ? '0 : PAdrM;
                    size_q   <= req_size;
                    spill_q  <= req_spill;
`ifdef LSU_BIGENDIAN_EN
                    be_q     <= BigEndianM;
`endif
                    state    <= BEAT0;
                end
                BEAT0: if (BeatValidM) begin
                    lo_buf <= BeatDataM;
                    if (spill_q) begin
                        state <= BEAT1;
                    end else begin
                        state      <= RESP;
                        read_data  <= ext;
                        resp_valid <= 1'b1;
                    end
                end
                BEAT1: if (BeatValidM) begin
                    hi_buf     <= BeatDataM;
                    state      <= RESP;
                    read_data  <= ext;
                    resp_valid <= 1'b1;
                end
                RESP: if (RespReadyM) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    spill_q    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ReqReadyM  = resetn && (state == IDLE);
    assign RespValidM = resetn && resp_valid;
    assign SpillM     = resetn && spill_q;
    assign ReadDataM  = read_data;

endmodule

// File: tb/tb_misaligned_load_align.sv
// Scoreboard bench for misaligned_load_align (LLEN=64); expectations come from a byte-array load model.
module tb_misaligned_load_align;

    localparam int unsigned LLEN    = 64;
    localparam int unsigned OFFBITS = 3;

    logic               clk = 1'b0;
    logic               resetn;
    logic               ReqValidM;
    logic               ReqReadyM;
    logic [OFFBITS-1:0] PAdrM;
    logic [2:0]         Funct3M;
    logic               FpLoadStoreM;
    logic               BigEndianM;
    logic               BeatValidM;
    logic [LLEN-1:0]    BeatDataM;
    logic               FlushM;
    logic               SpillM;
    logic               RespValidM;
    logic               RespReadyM;
    logic [LLEN-1:0]    ReadDataM;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    bit          ready_rand = 1'b0;

    always #5 clk = ~clk;

    misaligned_load_align #(.LLEN(LLEN), .OFFBITS(OFFBITS)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ReqValidM    (ReqValidM),
        .ReqReadyM    (ReqReadyM),
        .PAdrM        (PAdrM),
        .Funct3M      (Funct3M),
        .FpLoadStoreM (FpLoadStoreM),
        .BigEndianM   (BigEndianM),
        .BeatValidM   (BeatValidM),
        .BeatDataM    (BeatDataM),
        .FlushM       (FlushM),
        .SpillM       (SpillM),
        .RespValidM   (RespValidM),
        .RespReadyM   (RespReadyM),
        .ReadDataM    (ReadDataM)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3, input logic fp);
        if (f3 == 3'b111) return 8;
        if (f3 == 3'b100 && fp && LLEN == 128) return 16;
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic fp, input logic be,
                                             input int unsigned off, input logic [63:0] b0,
                                             input logic [63:0] b1);
        logic [7:0]  mem [16];
        logic [63:0] val;
        int unsigned sz;
        int unsigned pos;
        logic        fill;
        if (f3 == 3'b111) return b0;
        for (int unsigned k = 0; k < 8; k++) begin
            mem[k]     = b0[8*k +: 8];
            mem[k + 8] = b1[8*k +: 8];
        end
        sz  = ref_size(f3, fp);
        val = '0;
        for (int unsigned k = 0; k < sz; k++) begin
            pos = be ? (sz - 1 - k) : k;
            val[8*pos +: 8] = mem[off + k];
        end
        if (!f3[2] && sz < 8) begin
            fill = val[8*sz - 1];
            if (f3 != 3'b000) fill = fill | fp;
            if (fill) val = val | (~64'd0 << (8*sz));
        end
        return val;
    endfunction

    function automatic logic eff_be(input logic be);
`ifdef LSU_BIGENDIAN_EN
        return be;
`else
        return 1'b0 & be;
`endif
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!ReqReadyM && n < 200) begin
            BeatValidM = 1'($urandom_range(0, 1));
            BeatDataM  = rnd64();
            @(negedge clk);
            n++;
        end
        ok = ReqReadyM;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
    endtask

    task automatic send_beat(input logic [63:0] d);
        repeat ($urandom_range(0, 2)) begin
            BeatValidM = 1'b0;
            BeatDataM  = rnd64();
            @(negedge clk);
        end
        BeatValidM = 1'b1;
        BeatDataM  = d;
        @(negedge clk);
        BeatValidM = 1'b0;
        BeatDataM  = rnd64();
    endtask

    task automatic do_load(input logic [2:0] f3, input logic fp, input logic be, input int unsigned off,
                           input logic [63:0] b0, input logic [63:0] b1, input bit push,
                           input bit use_want, input logic [63:0] want, output logic [63:0] exp);
        bit   ok;
        logic exp_spill;
        exp       = use_want ? want : ref_load(f3, fp, eff_be(be), off, b0, b1);
        exp_spill = (f3 != 3'b111) && (off + ref_size(f3, fp) > 8);
        wait_ready(ok);
        if (!ok) return;
        if (push) exp_q.push_back(exp);
        ReqValidM    = 1'b1;
        Funct3M      = f3;
        FpLoadStoreM = fp;
        BigEndianM   = be;
        PAdrM        = OFFBITS'(off);
        @(negedge clk);
        ReqValidM    = 1'b0;
        BeatValidM   = 1'b0;
        Funct3M      = 3'($urandom);
        PAdrM        = OFFBITS'($urandom);
        check("spill", 64'(SpillM), 64'(exp_spill));
        check("ready_busy", 64'(ReqReadyM), 64'd0);
        send_beat(b0);
        if (exp_spill) send_beat(b1);
        check("resp_latency", 64'(RespValidM), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
        end
    endtask

    // Consumer side: randomly back-pressures after each active edge.
    initial begin
        RespReadyM = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            RespReadyM = ready_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops an expectation on every completed handshake, checks hold stability otherwise.
    initial begin
        bit          holding = 1'b0;
        logic [63:0] held    = '0;
        forever begin
            @(negedge clk);
            if (resetn && RespValidM) begin
                if (holding) check("hold_stable", ReadDataM, held);
                if (RespReadyM) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=%h expected=none", ReadDataM);
                    end else begin
                        check("resp_data", ReadDataM, exp_q.pop_front());
                    end
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = ReadDataM;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] e;
        logic [63:0] b0;
        logic [63:0] b1;
        resetn = 1'b0; ReqValidM = 1'b0; PAdrM = '0; Funct3M = '0; FpLoadStoreM = 1'b0;
        BigEndianM = 1'b0; BeatValidM = 1'b0; BeatDataM = '0; FlushM = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 64'(ReqReadyM), 64'd0);
        check("rst_resp_valid", 64'(RespValidM), 64'd0);
        check("rst_spill", 64'(SpillM), 64'd0);
        @(negedge clk);
        check("rst_read_data", ReadDataM, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(ReqReadyM), 64'd1);

        ready_rand = 1'b1;
        do_load(3'b010, 1'b0, 1'b0, 4, 64'h8765_4321_dead_beef, rnd64(), 1'b1, 1'b1,
                64'hFFFF_FFFF_8765_4321, e);
        b0 = {8'h34, 56'(rnd64())};
        b1 = {56'(rnd64()), 8'h12};
        do_load(3'b101, 1'b0, 1'b0, 7, b0, b1, 1'b1, 1'b1, 64'h0000_0000_0000_1234, e);
        do_load(3'b010, 1'b1, 1'b0, 0, {32'(rnd64()), 32'h3F80_0000}, rnd64(), 1'b1, 1'b1,
                64'hFFFF_FFFF_3F80_0000, e);
        b0 = {32'(rnd64()), 16'h3412, 16'(rnd64())};
`ifdef LSU_BIGENDIAN_EN
        do_load(3'b001, 1'b0, 1'b1, 2, b0, rnd64(), 1'b1, 1'b1, 64'h0000_0000_0000_1234, e);
`else
        do_load(3'b001, 1'b0, 1'b1, 2, b0, rnd64(), 1'b1, 1'b1, 64'h0000_0000_0000_3412, e);
`endif

        // Spilling ld flushed while its second beat arrives.
        begin
            bit ok;
            wait_ready(ok);
            if (ok) begin
                ReqValidM = 1'b1; Funct3M = 3'b011; FpLoadStoreM = 1'b0; BigEndianM = 1'b0; PAdrM = 3'd3;
                BeatValidM = 1'b0;
                @(negedge clk);
                ReqValidM = 1'b0;
                check("flush_spill", 64'(SpillM), 64'd1);
                BeatValidM = 1'b1; BeatDataM = rnd64();
                @(negedge clk);
                FlushM = 1'b1; BeatValidM = 1'b1; BeatDataM = rnd64();
                @(negedge clk);
                FlushM = 1'b0; BeatValidM = 1'b0;
                check("flush_resp_valid", 64'(RespValidM), 64'd0);
                check("flush_req_ready", 64'(ReqReadyM), 64'd1);
                repeat (3) @(negedge clk);
                check("flush_no_resp", 64'(RespValidM), 64'd0);
            end
        end
        do_load(3'b000, 1'b0, 1'b0, $urandom_range(0, 7), rnd64(), rnd64(), 1'b1, 1'b0, '0, e);

        for (int i = 0; i < 300; i++)
            do_load(3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7), rnd64(), rnd64(),
                    1'b1, 1'b0, '0, e);
        drain();

        // Response held under back-pressure, then reset while in RESP.
        ready_rand = 1'b0;
        @(negedge clk);
        do_load(3'b011, 1'b0, 1'b0, 5, rnd64(), rnd64(), 1'b0, 1'b0, '0, e);
        repeat (5) begin
            @(negedge clk);
            check("hold_data", ReadDataM, e);
            check("hold_valid", 64'(RespValidM), 64'd1);
        end
        resetn = 1'b0;
        @(negedge clk);
        check("rst_resp_valid_2", 64'(RespValidM), 64'd0);
        check("rst_read_data_2", ReadDataM, 64'd0);
        check("rst_spill_2", 64'(SpillM), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ReqReadyM), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/misaligned_load_align.md
# misaligned_load_align

Load-data alignment unit for the LSU, successor to the single-beat subword extractor. It accepts a load request (physical address offset, Funct3, FP flag, endianness), collects one or two LLEN-wide data beats from the D$/bus side, and assembles accesses that straddle an LLEN boundary. It then extracts, byte-orders, and sign-extends or NaN-boxes the result, presenting it through a valid/ready response port to the writeback stage.

## Interface
Parameters:
- LLEN, 64, load data width in bits; legal 32, 64, 128.
- OFFBITS, $clog2(LLEN/8), width of the byte offset within a beat.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ReqValidM  in  1  load request valid.
- ReqReadyM  out  1  unit can accept a request.
- PAdrM  in  OFFBITS  byte offset of the first byte within beat 0.
- Funct3M  in  3  load type (lb/lh/lw/ld/lbu/lhu/lwu; 100 with FpLoadStoreM and LLEN=128 = flq).
- FpLoadStoreM  in  1  FP load; upper bits are NaN-boxed with ones.
- BigEndianM  in  1  big-endian access.
- BeatValidM  in  1  BeatDataM valid this cycle.
- BeatDataM  in  LLEN  data beat, little-endian lane order.
- FlushM  in  1  abort the current operation.
- SpillM  out  1  the latched request needs two beats.
- RespValidM  out  1  ReadDataM valid.
- RespReadyM  in  1  consumer takes the response.
- ReadDataM  out  LLEN  extended result.

## Operation
- Size in bytes: Funct3[1:0] gives 1/2/4/8 bytes. Funct3=100 with FpLoadStoreM=1 and LLEN=128 gives 16 bytes.
- Illegal cases: Funct3=111, and 011 with LLEN=32. These are treated as a 1-beat raw pass-through of beat 0 with SpillM=0.
- Spill is computed when a request is accepted: SpillM = (PAdrM + size > LLEN/8). The sum is OFFBITS+1 wide, so the comparison has no wrap.
- State machine:
  - IDLE: ReqReadyM=1. A request is accepted on ReqValidM && ReqReadyM. The unit latches Funct3, FP flag, BigEndian, offset, and spill, then goes to BEAT0.
  - BEAT0: on BeatValidM, capture BeatDataM into the low buffer. Go to BEAT1 if spill, otherwise go to RESP and register the result.
  - BEAT1: on BeatValidM, capture BeatDataM into the high buffer, go to RESP, and register the result.
  - RESP: RespValidM=1 and ReadDataM is held stable. On RespReadyM, go to IDLE.
- Extraction:
  - Form the 2*LLEN window {high, low} and shift it right by 8*offset.
  - Take the low `size` bytes. If the request is big-endian, byte-reverse those bytes.
- Extension (zero-extend and sign-extend rules):
  - Zero-extend for lbu, lhu, lwu.
  - Sign-extend lb, lh, lw, ld. For lh, lw, ld, the fill bit is sign|FpLoadStoreM.
  - flq passes the data through.
- FlushM has priority over every other event. The next state is IDLE, RespValidM goes 0, and the buffers are discarded. A BeatValidM in the same cycle is ignored.
- BeatValidM is ignored in IDLE and RESP.

## Timing
- While resetn=0, ReqReadyM=0, RespValidM=0, and SpillM=0. On the edge with resetn=0, ReadDataM, the buffers, and the latched fields are cleared, and the state is set to IDLE.
- Minimum latency, request accept (cycle N) to RespValidM:
  - Non-spill: beat in N+1, response in N+2.
  - Spill: beats in N+1 and N+2, response in N+3.
- Beats may stall indefinitely; the state holds.
- ReqReadyM is combinational from the state. There is no back-to-back accept: at least one IDLE cycle follows each RESP.
- While RespValidM=1 and RespReadyM=0, ReadDataM and RespValidM must not change.

## Configuration
- LSU_BIGENDIAN_EN:
  - Defined: BigEndianM controls byte reversal as above.
  - Undefined: BigEndianM is ignored, the reversal logic is not built, and all accesses are little-endian.

## Structure
- Package entries (config_pkg-adjacent load-align package):
  - enum of the states IDLE/BEAT0/BEAT1/RESP.
  - function mapping Funct3/FP/LLEN to a byte size.
  - localparam OFFBITS rule.
- Sub-module: a combinational `loadextend` that takes the shifted window, size, Funct3, FP flag, and BigEndian, and produces ReadDataM. The top-level block holds the FSM and buffers.

## Test plan
- LLEN=64, lw, PAdrM=4, beat 0x8765_4321_xxxx_xxxx -> SpillM=0; after 2 cycles ReadDataM=0xFFFF_FFFF_8765_4321.
- LLEN=64, lhu, PAdrM=7, beat0 byte7=0x34, beat1 byte0=0x12 -> SpillM=1; ReadDataM=0x0000_0000_0000_1234 one cycle after beat1.
- LLEN=64, flw, PAdrM=0, data 0x3F80_0000 -> ReadDataM=0xFFFF_FFFF_3F80_0000.
- LSU_BIGENDIAN_EN defined, lh, PAdrM=2, bytes[2]=0x12, [3]=0x34 -> ReadDataM=0x0000_0000_0000_1234.
- Spill ld at PAdrM=3; FlushM asserted in BEAT1 together with BeatValidM -> next cycle IDLE, RespValidM=0, ReqReadyM=1; the following lb returns a correct value.
- RESP held with RespReadyM=0 for 5 cycles -> ReadDataM stable. resetn=0 in RESP -> RespValidM=0 and ReadDataM=0 on the next edge.
